// File: rtl/multilane_packet_receiver.sv
// ---------------------------------------------------------------------------
// multilane_packet_receiver
//
// Purpose:
//   Oversamples an external serial bit clock (clk_gpio) in the clk domain.
//   It hunts for a sync word on the header lane, then deserialises
//   DATA_LANES data lanes in parallel. Each frame is checked for per-lane
//   even parity and classified as a data frame or an ACK frame. Duplicate
//   data frames are suppressed. The block reports results as one-cycle
//   pulses and maintains small statistics counters.
//
// Ports:
//   clk                  system clock
//   rst_l                asynchronous active-low reset
//   game_active          receiver enable; low discards any frame in progress
//   clk_gpio             asynchronous serial bit clock (<= clk/8)
//   serial_in_h          header lane (sync word, type, seq, parity bits)
//   serial_in            data lanes
//   payload              lane i in payload[i*FRAME_BITS +: FRAME_BITS], first bit at MSB
//   data_valid           pulse: new, non-duplicate data frame on payload
//   data_seqNum          sequence bit of the current payload
//   ack_received         pulse: valid ACK frame received
//   ack_seqNum           sequence bit of the last ACK
//   send_ACK             pulse: ask the transmitter to ACK ack_req_seqNum
//   ack_req_seqNum       sequence bit to acknowledge
//   receive_done         pulse at the end of every frame, good or bad
//   packets_received_cnt valid data frames including duplicates (wraps)
//   acks_received_cnt    valid ACK frames (wraps)
//   error_cnt            parity failures plus timeouts (saturates)
//
// States:
//   S_HUNT  | shift header bits, looking for SYNC_WORD
//   S_RECV  | deserialise FRAME_BITS beats on every lane, watch for timeout
//   S_CHECK | one cycle: parity check, classify frame, register results
// ---------------------------------------------------------------------------
module multilane_packet_receiver #(
    parameter int                   DATA_LANES     = 4,
    parameter int                   FRAME_BITS     = 32,
    parameter int                   SYNC_BITS      = 8,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD      = 8'hA5,
    parameter int                   CNT_BITS       = 4,
    parameter int                   TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             game_active,
    input  logic                             clk_gpio,
    input  logic                             serial_in_h,
    input  logic [DATA_LANES-1:0]            serial_in,
    output logic [DATA_LANES*FRAME_BITS-1:0] payload,
    output logic                             data_valid,
    output logic                             data_seqNum,
    output logic                             ack_received,
    output logic                             ack_seqNum,
    output logic                             send_ACK,
    output logic                             ack_req_seqNum,
    output logic                             receive_done,
    output logic [CNT_BITS-1:0]              packets_received_cnt,
    output logic [CNT_BITS-1:0]              acks_received_cnt,
    output logic [CNT_BITS-1:0]              error_cnt
);

    localparam int HDR_W  = DATA_LANES + 2;
    localparam int BEAT_W = $clog2(FRAME_BITS);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BITS - 1);
    localparam logic [BEAT_W-1:0] LAST_HDR  = BEAT_W'(HDR_W - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Input synchronisers
    logic [1:0]            r_gpio_sync;
    logic                  r_gpio_d;
    logic [1:0]            r_hdr_sync;
    logic [DATA_LANES-1:0] r_lane_sync1;
    logic [DATA_LANES-1:0] r_lane_sync2;

    logic                  w_beat;
    logic                  w_hdr_bit;
    logic [DATA_LANES-1:0] w_lane_bits;

    // Only SYNC_BITS-1 bits of history are stored; the newest bit is joined
    // combinationally, so the compare sees the full register after the shift.
    logic [SYNC_BITS-2:0]  r_sync_hist;
    logic [SYNC_BITS-1:0]  w_sync_cand;

    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [HDR_W-1:0]      r_hdr_sh;
    logic [FRAME_BITS-1:0] r_lane_sh [DATA_LANES];

    logic                  r_last_seq;
    logic                  r_last_seq_vld;

    logic [DATA_LANES*FRAME_BITS-1:0] r_payload;
    logic                  r_data_valid;
    logic                  r_data_seq;
    logic                  r_ack_received;
    logic                  r_ack_seq;
    logic                  r_send_ack;
    logic                  r_ack_req_seq;
    logic                  r_receive_done;
    logic [CNT_BITS-1:0]   r_pkt_cnt;
    logic [CNT_BITS-1:0]   r_ack_cnt;
    logic [CNT_BITS-1:0]   r_err_cnt;

    // Decoded actions from the output process
    logic w_sync_hit;
    logic w_hunt_shift;
    logic w_recv_shift;
    logic w_to_dec;
    logic w_timeout;
    logic w_check;

    logic w_par_fail;
    logic w_frame_type;
    logic w_frame_seq;

    // ------------------------------------------------------------------
    // Synchronisers and beat detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_gpio_sync  <= '0;
            r_gpio_d     <= 1'b0;
            r_hdr_sync   <= '0;
            r_lane_sync1 <= '0;
            r_lane_sync2 <= '0;
        end else begin
            r_gpio_sync  <= {r_gpio_sync[0], clk_gpio};
            r_gpio_d     <= r_gpio_sync[1];
            r_hdr_sync   <= {r_hdr_sync[0], serial_in_h};
            r_lane_sync1 <= serial_in;
            r_lane_sync2 <= r_lane_sync1;
        end
    end

    // All lanes share the clock's synchroniser depth, so the lane values
    // seen on the beat cycle are the ones present at the serial edge.
    assign w_beat      = r_gpio_sync[1] & ~r_gpio_d;
    assign w_hdr_bit   = r_hdr_sync[1];
    assign w_lane_bits = r_lane_sync2;
    assign w_sync_cand = {r_sync_hist, w_hdr_bit};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!game_active) begin
            w_state_nxt = S_HUNT;
        end else begin
            case (r_state)
                S_HUNT: begin
                    if (w_beat && (w_sync_cand == SYNC_WORD)) begin
                        w_state_nxt = S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_beat && (r_beat_cnt == LAST_BEAT)) begin
                        w_state_nxt = S_CHECK;
                    end else if (!w_beat && (r_to_cnt == '0)) begin
                        w_state_nxt = S_HUNT;
                    end
                end
                S_CHECK: w_state_nxt = S_HUNT;
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_sync_hit   = 1'b0;
        w_hunt_shift = 1'b0;
        w_recv_shift = 1'b0;
        w_to_dec     = 1'b0;
        w_timeout    = 1'b0;
        w_check      = 1'b0;
        if (game_active) begin
            case (r_state)
                S_HUNT: begin
                    w_hunt_shift = w_beat;
                    w_sync_hit   = w_beat && (w_sync_cand == SYNC_WORD);
                end
                S_RECV: begin
                    w_recv_shift = w_beat;
                    w_to_dec     = !w_beat && (r_to_cnt != '0);
                    w_timeout    = !w_beat && (r_to_cnt == '0);
                end
                S_CHECK: begin
                    w_check      = 1'b1;
                    // A beat landing here belongs to the next hunt.
                    w_hunt_shift = w_beat;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    // Header beat k sits at r_hdr_sh[HDR_W-1-k] once all header beats are in.
    assign w_frame_type = r_hdr_sh[HDR_W-1];
    assign w_frame_seq  = r_hdr_sh[HDR_W-2];

    always_comb begin
        w_par_fail = 1'b0;
        for (int i = 0; i < DATA_LANES; i++) begin
            if ((^r_lane_sh[i]) != r_hdr_sh[DATA_LANES-1-i]) begin
                w_par_fail = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sync_hist    <= '0;
            r_beat_cnt     <= '0;
            r_to_cnt       <= TO_LOAD;
            r_hdr_sh       <= '0;
            for (int i = 0; i < DATA_LANES; i++) begin
                r_lane_sh[i] <= '0;
            end
            r_last_seq     <= 1'b0;
            r_last_seq_vld <= 1'b0;
            r_payload      <= '0;
            r_data_valid   <= 1'b0;
            r_data_seq     <= 1'b0;
            r_ack_received <= 1'b0;
            r_ack_seq      <= 1'b0;
            r_send_ack     <= 1'b0;
            r_ack_req_seq  <= 1'b0;
            r_receive_done <= 1'b0;
            r_pkt_cnt      <= '0;
            r_ack_cnt      <= '0;
            r_err_cnt      <= '0;
        end else begin
            r_data_valid   <= 1'b0;
            r_ack_received <= 1'b0;
            r_send_ack     <= 1'b0;
            r_receive_done <= 1'b0;

            if (!game_active) begin
                r_sync_hist <= '0;
            end else if (w_sync_hit) begin
                r_sync_hist <= '0;
                r_beat_cnt  <= '0;
                r_to_cnt    <= TO_LOAD;
            end else if (w_hunt_shift) begin
                r_sync_hist <= w_sync_cand[SYNC_BITS-2:0];
            end

            if (w_recv_shift) begin
                for (int i = 0; i < DATA_LANES; i++) begin
                    r_lane_sh[i] <= {r_lane_sh[i][FRAME_BITS-2:0], w_lane_bits[i]};
                end
                // Header beats past the parity bits are don't-care; freezing
                // the register keeps type/seq/parity at fixed positions.
                if (r_beat_cnt <= LAST_HDR) begin
                    r_hdr_sh <= {r_hdr_sh[HDR_W-2:0], w_hdr_bit};
                end
                r_beat_cnt <= r_beat_cnt + 1'b1;
                r_to_cnt   <= TO_LOAD;
            end else if (w_to_dec) begin
                r_to_cnt <= r_to_cnt - 1'b1;
            end

            if (w_timeout) begin
                r_receive_done <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end

            if (w_check) begin
                r_receive_done <= 1'b1;
                if (w_par_fail) begin
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end else if (w_frame_type) begin
                    r_ack_received <= 1'b1;
                    r_ack_seq      <= w_frame_seq;
                    r_ack_cnt      <= r_ack_cnt + 1'b1;
                end else begin
                    r_pkt_cnt     <= r_pkt_cnt + 1'b1;
                    r_send_ack    <= 1'b1;
                    r_ack_req_seq <= w_frame_seq;
                    // The peer resends on a lost ACK; re-ACK but deliver once.
                    if (!(r_last_seq_vld && (w_frame_seq == r_last_seq))) begin
                        for (int i = 0; i < DATA_LANES; i++) begin
                            r_payload[i*FRAME_BITS +: FRAME_BITS] <= r_lane_sh[i];
                        end
                        r_data_seq     <= w_frame_seq;
                        r_data_valid   <= 1'b1;
                        r_last_seq     <= w_frame_seq;
                        r_last_seq_vld <= 1'b1;
                    end
                end
            end
        end
    end

    assign payload              = r_payload;
    assign data_valid           = r_data_valid;
    assign data_seqNum          = r_data_seq;
    assign ack_received         = r_ack_received;
    assign ack_seqNum           = r_ack_seq;
    assign send_ACK             = r_send_ack;
    assign ack_req_seqNum       = r_ack_req_seq;
    assign receive_done         = r_receive_done;
    assign packets_received_cnt = r_pkt_cnt;
    assign acks_received_cnt    = r_ack_cnt;
    assign error_cnt            = r_err_cnt;

endmodule

// File: tb/tb_multilane_packet_receiver.sv
// ---------------------------------------------------------------------------
// tb_multilane_packet_receiver
//
// Drives framed serial traffic (clk_gpio = clk/10) into the receiver. A
// frame-level reference model predicts the pulses and the register state
// that each frame should leave behind.
// ---------------------------------------------------------------------------
module tb_multilane_packet_receiver;

    localparam int DL = 4;
    localparam int FB = 16;
    localparam logic [7:0] SW = 8'hA5;

    logic            clk = 1'b0;
    logic            rst_l = 1'b0;
    logic            game_active = 1'b0;
    logic            clk_gpio = 1'b0;
    logic            serial_in_h = 1'b0;
    logic [DL-1:0]   serial_in = '0;
    logic [DL*FB-1:0] payload;
    logic            data_valid, data_seqNum, ack_received, ack_seqNum;
    logic            send_ACK, ack_req_seqNum, receive_done;
    logic [3:0]      packets_received_cnt, acks_received_cnt, error_cnt;

    multilane_packet_receiver #(
        .DATA_LANES(DL), .FRAME_BITS(FB), .SYNC_BITS(8), .SYNC_WORD(SW),
        .CNT_BITS(4), .TIMEOUT_CYCLES(4096)
    ) u_dut (
        .clk(clk), .rst_l(rst_l), .game_active(game_active),
        .clk_gpio(clk_gpio), .serial_in_h(serial_in_h), .serial_in(serial_in),
        .payload(payload), .data_valid(data_valid), .data_seqNum(data_seqNum),
        .ack_received(ack_received), .ack_seqNum(ack_seqNum),
        .send_ACK(send_ACK), .ack_req_seqNum(ack_req_seqNum),
        .receive_done(receive_done),
        .packets_received_cnt(packets_received_cnt),
        .acks_received_cnt(acks_received_cnt), .error_cnt(error_cnt)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor
    int   c_dv = 0, c_sa = 0, c_ar = 0, c_rd = 0, dbl = 0;
    logic p_dv = 0, p_sa = 0, p_ar = 0, p_rd = 0;

    always @(negedge clk) begin
        if (data_valid)   c_dv++;
        if (send_ACK)     c_sa++;
        if (ack_received) c_ar++;
        if (receive_done) c_rd++;
        if ((data_valid && p_dv) || (send_ACK && p_sa) ||
            (ack_received && p_ar) || (receive_done && p_rd)) dbl++;
        p_dv = data_valid;
        p_sa = send_ACK;
        p_ar = ack_received;
        p_rd = receive_done;
    end

    task automatic clear_counts();
        c_dv = 0; c_sa = 0; c_ar = 0; c_rd = 0;
    endtask

    // Reference model state
    logic [63:0] m_payload;
    logic        m_dseq, m_aseq, m_rseq, m_lv, m_ls;
    int          m_pk, m_ak, m_er;

    task automatic model_reset();
        m_payload = '0; m_dseq = 0; m_aseq = 0; m_rseq = 0;
        m_lv = 0; m_ls = 0; m_pk = 0; m_ak = 0; m_er = 0;
    endtask

    task automatic check_all(input int e_dv, input int e_sa, input int e_ar, input int e_rd);
        chk("data_valid_pulses",   c_dv, e_dv);
        chk("send_ACK_pulses",     c_sa, e_sa);
        chk("ack_received_pulses", c_ar, e_ar);
        chk("receive_done_pulses", c_rd, e_rd);
        chk("payload",        payload,        m_payload);
        chk("data_seqNum",    data_seqNum,    m_dseq);
        chk("ack_seqNum",     ack_seqNum,     m_aseq);
        chk("ack_req_seqNum", ack_req_seqNum, m_rseq);
        chk("packets_cnt",    packets_received_cnt, m_pk % 16);
        chk("acks_cnt",       acks_received_cnt,    m_ak % 16);
        chk("error_cnt",      error_cnt,            m_er);
    endtask

    task automatic beat(input logic h, input logic [DL-1:0] d);
        @(negedge clk);
        clk_gpio = 1'b0; serial_in_h = h; serial_in = d;
        repeat (5) @(negedge clk);
        clk_gpio = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) beat(w[i], DL'($urandom));
    endtask

    task automatic send_body(input logic typ, input logic seq, input logic [63:0] lanes,
                             input logic [3:0] bad, input int nbeats);
        logic [FB-1:0] ln;
        logic          h;
        logic [DL-1:0] d;
        for (int b = 0; b < nbeats; b++) begin
            if (b == 0)           h = typ;
            else if (b == 1)      h = seq;
            else if (b < 2 + DL) begin
                ln = lanes[(b-2)*FB +: FB];
                h  = (^ln) ^ bad[b-2];
            end else              h = 1'($urandom);
            for (int i = 0; i < DL; i++) begin
                ln   = lanes[i*FB +: FB];
                d[i] = ln[FB-1-b];
            end
            beat(h, d);
        end
    endtask

    task automatic run_frame(input logic typ, input logic seq, input logic [63:0] lanes,
                             input logic [3:0] bad);
        int e_dv, e_sa, e_ar;
        clear_counts();
        send_bits8(SW);
        send_body(typ, seq, lanes, bad, FB);
        repeat (12) @(negedge clk);
        e_dv = 0; e_sa = 0; e_ar = 0;
        if (bad != 0) begin
            if (m_er < 15) m_er++;
        end else if (typ) begin
            e_ar = 1; m_aseq = seq; m_ak++;
        end else begin
            e_sa = 1; m_rseq = seq; m_pk++;
            if (!(m_lv && m_ls == seq)) begin
                e_dv = 1; m_payload = lanes; m_dseq = seq; m_lv = 1; m_ls = seq;
            end
        end
        check_all(e_dv, e_sa, e_ar, 1);
    endtask

    localparam logic [63:0] L0 = 64'hFFFF0F0FABCD1234;

    initial begin
        logic [63:0] rl;
        model_reset();
        repeat (3) @(negedge clk);
        check_all(0, 0, 0, 0);
        rst_l = 1'b1;
        game_active = 1'b1;
        repeat (3) @(negedge clk);
        check_all(0, 0, 0, 0);

        // Data, duplicate, next sequence, ACK, parity failure
        run_frame(1'b0, 1'b0, L0, 4'b0000);
        chk("plan_payload", payload, 64'hFFFF0F0FABCD1234);
        run_frame(1'b0, 1'b0, L0, 4'b0000);
        run_frame(1'b0, 1'b1, {$urandom, $urandom}, 4'b0000);
        run_frame(1'b1, 1'b1, {$urandom, $urandom}, 4'b0000);
        run_frame(1'b0, 1'b0, {$urandom, $urandom}, 4'b0100);

        // Serial clock stalls mid-frame
        clear_counts();
        send_bits8(SW);
        send_body(1'b0, 1'b0, {$urandom, $urandom}, 4'b0000, 5);
        repeat (5000) @(negedge clk);
        if (m_er < 15) m_er++;
        check_all(0, 0, 0, 1);

        // Error counter saturation
        for (int k = 0; k < 20; k++)
            run_frame(1'($urandom), 1'($urandom), {$urandom, $urandom}, 4'b0100);
        chk("error_saturated", error_cnt, 4'hF);

        // Enable dropped at beat 7, then a clean frame
        clear_counts();
        send_bits8(SW);
        send_body(1'b0, ~m_ls, {$urandom, $urandom}, 4'b0000, 7);
        @(negedge clk) game_active = 1'b0;
        repeat (3) @(negedge clk);
        game_active = 1'b1;
        repeat (2) @(negedge clk);
        check_all(0, 0, 0, 0);
        run_frame(1'b0, ~m_ls, {$urandom, $urandom}, 4'b0000);

        // Near-miss header A4 and 3 noise bits before the real sync word
        clear_counts();
        send_bits8(8'hA4);
        beat(1'b0, '0); beat(1'b1, '0); beat(1'b1, '0);
        run_frame(1'b0, ~m_ls, {$urandom, $urandom}, 4'b0000);

        // Random traffic
        for (int k = 0; k < 12; k++) begin
            rl = {$urandom, $urandom};
            run_frame(($urandom_range(0, 3) == 0), 1'($urandom), rl,
                      ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000);
        end

        // Reset mid-frame
        send_bits8(SW);
        send_body(1'b0, 1'b1, {$urandom, $urandom}, 4'b0000, 5);
        @(negedge clk) rst_l = 1'b0;
        clear_counts();
        @(negedge clk);
        model_reset();
        check_all(0, 0, 0, 0);
        rst_l = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            run_frame(1'b0, 1'($urandom), {$urandom, $urandom}, 4'b0000);

        chk("no_double_pulse", dbl, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
